// File: rtl/hook_ctrl_if.sv
// hook_ctrl_if: item RAM port; master = hook controller, slave = RAM/arbiter side.
interface hook_ctrl_if #(parameter int IDX_W = 4);
  logic [IDX_W-1:0] item_addr;
  logic [31:0] item_wdata;
  logic item_we;
  logic [31:0] item_rdata;
  logic ram_busy;
  modport master(output item_addr, item_wdata, item_we, input item_rdata, ram_busy);
  modport slave(input item_addr, item_wdata, item_we, output item_rdata, ram_busy);
endinterface

// File: rtl/hook_ctrl.sv
// hook_ctrl: rope/hook FSM - swing, extend, scan item RAM for a hit, drag item back, score, hold.
// Define HOOK_BOMB_EN to add bomb/bomb_avail inputs and a bomb_used strobe that destroys a carried item.
module hook_ctrl #(
  parameter int ORIGIN_X = 160, ORIGIN_Y = 45, ANG_MIN = 15, ANG_MAX = 165, SWING_STEP = 1,
  parameter int LEN_MIN = 10, LEN_MAX = 200, DOWN_STEP = 4, UP_EMPTY = 8,
  parameter int UP_STONE = 1, UP_GOLD = 2, UP_DIAMOND = 6,
  parameter int SCORE_STONE = 1, SCORE_GOLD = 2, SCORE_DIAMOND = 5,
  parameter int IDX_W = 4, HOLD_FRAMES = 3
) (
  input  logic clock,
  input  logic resetn,
  input  logic enable,
  input  logic frame_tick,
  input  logic go,
  input  logic [IDX_W-1:0] item_count,
  input  logic [8:0] sin_mag,
  input  logic [8:0] cos_mag,
  input  logic cos_pos,
`ifdef HOOK_BOMB_EN
  input  logic bomb,
  input  logic bomb_avail,
  output logic bomb_used,
`endif
  hook_ctrl_if.master ram,
  output logic [7:0] degree,
  output logic [9:0] rope_len,
  output logic [9:0] end_x,
  output logic [9:0] end_y,
  output logic score_add,
  output logic [7:0] score_val,
  output logic busy
);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  typedef enum logic [3:0] {IDLE, SWING, EXTEND, SCAN_RD, SCAN_CHK, HIT_WR, RETRACT,
                            MOVE_CALC, MOVE_WR, SCORE, HOLD, BOMB_WR} state_t;
  state_t state_q, state_d;
  logic dir_q, dir_d, carry_q, carry_d, score_add_q, score_add_d, wr_ok, hit, drop;
  logic [7:0] degree_q, degree_d, score_val_q, score_val_d, dec, inc, pts;
  logic [9:0] rope_len_q, rope_len_d, end_x_q, end_x_d, end_y_q, end_y_d, dx, dy, ext, step, ex8, ey8;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic [31:0] word_q, word_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [13:0] hx;
  logic [12:0] hy;
  logic [1:0] ty;
  assign wr_ok = !ram.ram_busy;
  assign hx = {1'b0, ram.item_rdata[31:19]};
  assign hy = {1'b0, ram.item_rdata[18:7]};
  assign hit = ram.item_rdata[1] && !ram.item_rdata[0] &&
               {4'b0, end_x_q} > hx && {4'b0, end_x_q} < hx + 14'd16 &&
               {3'b0, end_y_q} > hy && {3'b0, end_y_q} < hy + 13'd16;
  assign ty = word_q[3:2];
  assign step = !carry_q ? 10'(UP_EMPTY) : ty == 2'd1 ? 10'(UP_GOLD) : ty == 2'd2 ? 10'(UP_DIAMOND) : 10'(UP_STONE);
  assign pts = ty == 2'd0 ? 8'(SCORE_STONE) : ty == 2'd1 ? 8'(SCORE_GOLD) : ty == 2'd2 ? 8'(SCORE_DIAMOND) : 8'd0;
  assign dx = 10'((18'(rope_len_q) * 18'(cos_mag)) >> 8);
  assign dy = 10'((18'(rope_len_q) * 18'(sin_mag)) >> 8);
  assign end_x_d = cos_pos ? 10'(ORIGIN_X) + dx : 10'(ORIGIN_X) - dx;
  assign end_y_d = 10'(ORIGIN_Y) + dy;
  // MOVE_CALC sits one cycle after rope_len changed, so the fresh tip is end_*_d, not end_*_q
  assign ex8 = end_x_d < 10'd8 ? 10'd0 : end_x_d - 10'd8;
  assign ey8 = end_y_d < 10'd8 ? 10'd0 : end_y_d - 10'd8;
  assign ext = rope_len_q + 10'(DOWN_STEP);
  assign dec = degree_q - 8'(SWING_STEP);
  assign inc = degree_q + 8'(SWING_STEP);
  assign ram.item_addr = addr_q;
  assign ram.item_we = wr_ok && (state_q == HIT_WR || state_q == MOVE_WR || state_q == SCORE || state_q == BOMB_WR);
  assign ram.item_wdata = (state_q == SCORE || state_q == BOMB_WR) ? {word_q[31:2], 2'b00} : word_q;
  assign degree = degree_q;
  assign rope_len = rope_len_q;
  assign end_x = end_x_q;
  assign end_y = end_y_q;
  assign score_add = score_add_q;
  assign score_val = score_val_q;
  assign busy = !(state_q == IDLE || state_q == SWING);
`ifdef HOOK_BOMB_EN
  logic bomb_used_q, bomb_used_d;
  assign drop = bomb && bomb_avail;
  always_comb bomb_used_d = state_q == BOMB_WR && wr_ok;
  always_ff @(posedge clock) bomb_used_q <= resetn && bomb_used_d;
  assign bomb_used = bomb_used_q;
`else
  assign drop = 1'b0;
`endif
  always_comb begin
    state_d = state_q; dir_d = dir_q; carry_d = carry_q; degree_d = degree_q; rope_len_d = rope_len_q;
    addr_d = addr_q; word_d = word_q; hold_d = hold_q; score_add_d = 1'b0; score_val_d = score_val_q;
    case (state_q)
      IDLE: state_d = enable ? SWING : IDLE;
      SWING:
        if (!enable) state_d = IDLE;
        else if (go) state_d = EXTEND;
        else if (frame_tick) begin
          degree_d = dir_q ? (inc >= 8'(ANG_MAX) ? 8'(ANG_MAX) : inc) : (dec <= 8'(ANG_MIN) ? 8'(ANG_MIN) : dec);
          dir_d = dir_q ? !(inc >= 8'(ANG_MAX)) : dec <= 8'(ANG_MIN);
        end
      EXTEND:
        if (frame_tick) begin
          rope_len_d = ext >= 10'(LEN_MAX) ? 10'(LEN_MAX) : ext;
          carry_d = 1'b0;
          addr_d = '0;
          state_d = ext >= 10'(LEN_MAX) ? RETRACT : item_count == '0 ? EXTEND : SCAN_RD;
        end
      SCAN_RD: state_d = wr_ok ? SCAN_CHK : SCAN_RD;
      SCAN_CHK:
        if (hit) begin
          word_d = ram.item_rdata | 32'd1;
          state_d = HIT_WR;
        end else if ({1'b0, addr_q} + 1'b1 < {1'b0, item_count}) begin
          addr_d = addr_q + 1'b1;
          state_d = SCAN_RD;
        end else state_d = EXTEND;
      HIT_WR:
        if (wr_ok) begin
          carry_d = 1'b1;
          state_d = RETRACT;
        end
      RETRACT:
        if (carry_q && drop) state_d = BOMB_WR;
        else if (frame_tick) begin
          rope_len_d = rope_len_q < 10'(LEN_MIN) + step ? 10'(LEN_MIN) : rope_len_q - step;
          state_d = carry_q ? MOVE_CALC : rope_len_d == 10'(LEN_MIN) ? SWING : RETRACT;
        end
      MOVE_CALC: begin
        word_d = {13'(ex8), 12'(ey8), word_q[6:0]};
        state_d = MOVE_WR;
      end
      MOVE_WR: if (wr_ok) state_d = rope_len_q == 10'(LEN_MIN) ? SCORE : RETRACT;
      SCORE:
        if (wr_ok) begin
          score_add_d = 1'b1;
          score_val_d = pts;
          carry_d = 1'b0;
          hold_d = '0;
          state_d = HOLD;
        end
      HOLD:
        if (frame_tick) begin
          hold_d = hold_q + 1'b1;
          state_d = hold_q == HW'(HOLD_FRAMES - 1) ? SWING : HOLD;
        end
      BOMB_WR:
        if (wr_ok) begin
          carry_d = 1'b0;
          state_d = RETRACT;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (!resetn) begin
      state_q <= IDLE; dir_q <= 1'b0; carry_q <= 1'b0; degree_q <= 8'd90; rope_len_q <= 10'(LEN_MIN);
      end_x_q <= 10'(ORIGIN_X); end_y_q <= 10'(ORIGIN_Y); addr_q <= '0; word_q <= '0; hold_q <= '0;
      score_add_q <= 1'b0; score_val_q <= 8'd0;
    end else begin
      state_q <= state_d; dir_q <= dir_d; carry_q <= carry_d; degree_q <= degree_d; rope_len_q <= rope_len_d;
      end_x_q <= end_x_d; end_y_q <= end_y_d; addr_q <= addr_d; word_q <= word_d; hold_q <= hold_d;
      score_add_q <= score_add_d; score_val_q <= score_val_d;
    end
endmodule

// File: tb/tb_hook_ctrl.sv
// tb_hook_ctrl: directed stimulus with a scoreboard of expected RAM writes / score / bomb strobes.
`timescale 1ns/1ps
module tb_hook_ctrl;
  typedef struct packed {logic [1:0] kind; logic [3:0] addr; logic [31:0] data;} ev_t;
  localparam real PI = 3.14159265358979;
  localparam logic [31:0] FAR = {13'd400, 12'd10, 5'd0, 2'b10};
  logic clock = 1'b0, resetn = 1'b0, enable = 1'b0, frame_tick = 1'b0, go = 1'b0, cos_pos, load = 1'b0;
  logic [3:0] item_count = 4'd0;
  logic [8:0] sin_mag, cos_mag;
  logic [7:0] degree, score_val;
  logic [9:0] rope_len, end_x, end_y;
  logic score_add, busy;
  logic [31:0] mem [16];
  logic [31:0] img [16];
  ev_t exp_q[$];
  int checks = 0, fails = 0;
`ifdef HOOK_BOMB_EN
  logic bomb = 1'b0, bomb_avail = 1'b0, bomb_used;
`endif
  hook_ctrl_if #(.IDX_W(4)) ram();
  hook_ctrl dut (
    .clock(clock), .resetn(resetn), .enable(enable), .frame_tick(frame_tick), .go(go),
    .item_count(item_count), .sin_mag(sin_mag), .cos_mag(cos_mag), .cos_pos(cos_pos),
`ifdef HOOK_BOMB_EN
    .bomb(bomb), .bomb_avail(bomb_avail), .bomb_used(bomb_used),
`endif
    .ram(ram), .degree(degree), .rope_len(rope_len), .end_x(end_x), .end_y(end_y),
    .score_add(score_add), .score_val(score_val), .busy(busy));
  always #5 clock = ~clock;
  function automatic logic [8:0] mag(input real v);
    real a;
    a = v < 0.0 ? -v : v;
    return 9'($rtoi(a * 256.0 + 0.5));
  endfunction
  assign sin_mag = mag($sin(real'(degree) * PI / 180.0));
  assign cos_mag = mag($cos(real'(degree) * PI / 180.0));
  assign cos_pos = $cos(real'(degree) * PI / 180.0) >= 0.0;
  always @(posedge clock) begin
    if (load) for (int i = 0; i < 16; i++) mem[i] <= img[i];
    else if (ram.item_we) mem[ram.item_addr] <= ram.item_wdata;
    ram.item_rdata <= mem[ram.item_addr];
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask
  task automatic post(input ev_t a, input string name);
    if (exp_q.size() == 0) begin
      checks++; fails++;
      $display("FAIL %s: unexpected event %0h, required none", name, a);
    end else chk(name, 64'(a), 64'(exp_q.pop_front()));
  endtask
  always @(negedge clock) if (resetn) begin
    if (ram.item_we) begin
      chk("we_vs_busy", 64'(ram.ram_busy), 64'd0);
      post({2'd0, ram.item_addr, ram.item_wdata}, "ram_write");
    end
    if (score_add) post({2'd1, 28'd0, score_val}, "score");
`ifdef HOOK_BOMB_EN
    if (bomb_used) post({2'd2, 36'd0}, "bomb_used");
`endif
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic tick();
    frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(47);
  endtask
  task automatic do_reset();
    resetn = 1'b0; enable = 1'b0; go = 1'b0; frame_tick = 1'b0; ram.ram_busy = 1'b0; load = 1'b1;
    cyc(3);
    load = 1'b0; resetn = 1'b1;
  endtask
  function automatic logic [31:0] at_tip(input logic [12:0] x, input logic [1:0] ty, input logic [1:0] vm);
    return {x, 12'd140, 3'd0, ty, vm};
  endfunction
  function automatic ev_t wr(input int a, input logic [31:0] d);
    return {2'd0, 4'(a), d};
  endfunction
  // tip at degree 90 sits at x=160, y=45+len; dragged item is drawn at tip-8
  function automatic logic [31:0] moved(input logic [31:0] w, input int l, input logic [1:0] vm);
    return {13'd152, 12'(45 + l - 8), w[6:2], vm};
  endfunction
  task automatic catch_run(input int cnt, input int idx, input int up, input int pts, input bit stall, input int bomb_at);
    logic [31:0] w = img[idx];
    int l = 98, n = 0, s;
    bit car = 1'b1;
    item_count = 4'(cnt);
    exp_q.push_back(wr(idx, w | 32'd1));
    while (l > 10) begin
      if (car && n == bomb_at) begin
        exp_q.push_back(wr(idx, moved(w, l, 2'b00)));
        exp_q.push_back({2'd2, 36'd0});
        car = 1'b0;
      end
      s = car ? up : 8;
      l = l - s < 10 ? 10 : l - s;
      if (car) exp_q.push_back(wr(idx, moved(w, l, 2'b11)));
      n++;
    end
    if (car) begin
      exp_q.push_back(wr(idx, moved(w, 10, 2'b00)));
      exp_q.push_back({2'd1, 28'd0, 8'(pts)});
    end
    enable = 1'b1; cyc(2); go = 1'b1; cyc(1); go = 1'b0; cyc(2);
    for (int k = 0; k < 22; k++) begin
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
      if (stall && k == 21) begin
        cyc(3); ram.ram_busy = 1'b1; cyc(10); ram.ram_busy = 1'b0;
      end
      cyc(40);
    end
    chk("hit_len", 64'(rope_len), 64'd98);
    chk("hit_busy", 64'(busy), 64'd1);
    chk("hit_word", 64'(mem[idx]), 64'(w | 32'd1));
    for (int k = 0; k < n; k++) begin
`ifdef HOOK_BOMB_EN
      if (k == bomb_at) begin
        bomb = 1'b1; bomb_avail = 1'b1; cyc(1); bomb = 1'b0; bomb_avail = 1'b0; cyc(3);
      end
`endif
      tick();
    end
    repeat (3) tick();
    for (int i = 0; i < 200 && busy; i++) cyc(1);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_len", 64'(rope_len), 64'd10);
    chk("end_queue", 64'(exp_q.size()), 64'd0);
    chk("end_hidden", 64'(mem[idx][1:0]), 64'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 16; i++) img[i] = FAR;
    do_reset();
    chk("rst_degree", 64'(degree), 64'd90);
    chk("rst_len", 64'(rope_len), 64'd10);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_we", 64'(ram.item_we), 64'd0);
    chk("rst_score", 64'(score_add), 64'd0);
    chk("rst_addr", 64'(ram.item_addr), 64'd0);
    enable = 1'b1; cyc(2);
    chk("tip_x", 64'(end_x), 64'd160);
    chk("tip_y", 64'(end_y), 64'd55);
    repeat (74) tick();
    chk("swing_74", 64'(degree), 64'd16);
    tick(); chk("swing_clamp", 64'(degree), 64'd15);
    tick(); chk("swing_cw1", 64'(degree), 64'd16);
    tick(); chk("swing_cw2", 64'(degree), 64'd17);
    enable = 1'b0; cyc(2); tick();
    chk("idle_hold", 64'(degree), 64'd17);
    go = 1'b1; cyc(1); go = 1'b0; cyc(3);
    chk("idle_go", 64'(busy), 64'd0);
    do_reset();
    item_count = 4'd0; enable = 1'b1; cyc(2); go = 1'b1; cyc(1); go = 1'b0; cyc(2);
    chk("ext_busy", 64'(busy), 64'd1);
    for (int k = 1; k <= 48; k++) begin
      tick();
      chk("ext_len", 64'(rope_len), 64'(10 + 4 * k > 200 ? 200 : 10 + 4 * k));
    end
    for (int k = 1; k <= 24; k++) begin
      tick();
      chk("ret_len", 64'(rope_len), 64'(200 - 8 * k < 10 ? 10 : 200 - 8 * k));
    end
    chk("ret_busy", 64'(busy), 64'd0);
    chk("ret_degree", 64'(degree), 64'd90);
    img[0] = at_tip(13'd156, 2'd1, 2'b11);
    img[1] = at_tip(13'd156, 2'd1, 2'b00);
    img[2] = at_tip(13'd156, 2'd1, 2'b10);
    do_reset();
    catch_run(4, 2, 2, 2, 1'b0, -1);
    do_reset();
    catch_run(4, 2, 2, 2, 1'b1, -1);
    for (int i = 0; i < 16; i++) img[i] = FAR;
    img[0] = at_tip(13'd144, 2'd1, 2'b10);
    img[3] = at_tip(13'd156, 2'd2, 2'b10);
    img[5] = at_tip(13'd156, 2'd0, 2'b10);
    do_reset();
    catch_run(6, 3, 6, 5, 1'b0, -1);
    chk("item5_kept", 64'(mem[5]), 64'(img[5]));
    chk("item0_kept", 64'(mem[0]), 64'(img[0]));
`ifdef HOOK_BOMB_EN
    for (int i = 0; i < 16; i++) img[i] = FAR;
    img[0] = at_tip(13'd156, 2'd2, 2'b10);
    do_reset();
    catch_run(1, 0, 6, 5, 1'b0, 2);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
